// File: rtl/cgra_col_mem_arb_pkg.sv
// Shared types and constants for the CGRA column memory-port arbiter.
package cgra_col_mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  localparam int MEM_ARB_MAX_OUT = 2;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cgra_col_mem_arb_if.sv
// Column memory-port bundle: the arbiter is the master, the data memory the slave.
interface cgra_col_mem_arb_if #(
  parameter int DP_WIDTH       = 32,
  parameter int RC_CONST_WIDTH = 13
);

  logic                      data_req;
  logic                      data_wen;
  logic                      data_ind;
  logic [DP_WIDTH-1:0]       data_add;
  logic [DP_WIDTH-1:0]       data_wdata;
  logic [RC_CONST_WIDTH-1:0] add_inc;
  logic                      data_gnt;
  logic                      data_rvalid;
  logic [DP_WIDTH-1:0]       data_rdata;

  modport master (
    output data_req, data_wen, data_ind, data_add, data_wdata, add_inc,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_wen, data_ind, data_add, data_wdata, add_inc,
    output data_gnt, data_rvalid, data_rdata
  );

endinterface

// File: rtl/cgra_col_mem_arb_idx_fifo.sv
// Requester-index FIFO that routes in-order read returns back to their RC.
module cgra_idx_fifo
  import cgra_col_mem_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [2**PTR_W];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign full_o  = (count_r == CNT_W'(DEPTH));
  assign empty_o = (count_r == {CNT_W{1'b0}});
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign dout_o  = mem_r[rd_ptr_r];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Entry storage; contents are don't-care while not counted.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din_i;
    end
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cgra_col_mem_arb.sv
// Per-column arbiter: N_REQ cells share one data-memory port, with fixed or
// round-robin priority and up to MAX_OUT in-flight reads routed back in order.
module cgra_col_mem_arb
  import cgra_col_mem_arb_pkg::*;
#(
  parameter int        N_REQ          = 4,
  parameter int        DP_WIDTH       = 32,
  parameter int        RC_CONST_WIDTH = 13,
  parameter int        MAX_OUT        = MEM_ARB_MAX_OUT,
  parameter arb_mode_t ARB_MODE       = ARB_FIXED
) (
  input  logic                                  clk_i,
  input  logic                                  rst_col_i,
  input  logic                                  pc_en_i,
  input  logic [N_REQ-1:0]                      req_i,
  input  logic [N_REQ-1:0]                      wen_i,
  input  logic [N_REQ-1:0]                      ind_i,
  input  logic [N_REQ-1:0][DP_WIDTH-1:0]        add_i,
  input  logic [N_REQ-1:0][DP_WIDTH-1:0]        wdata_i,
  input  logic [N_REQ-1:0][RC_CONST_WIDTH-1:0]  add_inc_i,
  output logic [N_REQ-1:0]                      rvalid_o,
  output logic [DP_WIDTH-1:0]                   rdata_o,
  output logic [1:0]                            rflag_o,
  output logic                                  stall_o,
  output logic                                  err_o,
  cgra_col_mem_arb_if.master                    mem
);

  localparam int IDX_W = idx_width(N_REQ);

  logic [N_REQ-1:0]          served_r;
  logic [N_REQ-1:0]          returned_r;
  logic [IDX_W-1:0]          rr_ptr_r;
  logic                      err_r;

  logic [N_REQ-1:0]          eligible_s;
  logic [IDX_W-1:0]          base_s;
  logic [IDX_W-1:0]          winner_s;
  logic [IDX_W-1:0]          head_s;
  logic                      any_elig_s;
  logic                      grant_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [N_REQ-1:0]          grant_mask_s;
  logic [N_REQ-1:0]          rvalid_s;
  logic [DP_WIDTH-1:0]       rdata_s;
  logic                      port_wen_s;
  logic                      port_ind_s;
  logic [DP_WIDTH-1:0]       port_add_s;
  logic [DP_WIDTH-1:0]       port_wdata_s;
  logic [RC_CONST_WIDTH-1:0] port_inc_s;

  // Rotate so that base sits at bit 0, then take the first set bit.
  function automatic logic [IDX_W-1:0] pick_first(input logic [N_REQ-1:0] vec,
                                                  input logic [IDX_W-1:0] base);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   res;
    dbl = {vec, vec} >> base;
    rot = dbl[N_REQ-1:0];
    res = {IDX_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        res = IDX_W'((i + int'(base)) % N_REQ);
      end
    end
    return res;
  endfunction

  // Reads are held off on the registered full flag, never bypassed same-cycle.
  assign base_s       = (ARB_MODE == ARB_RR) ? rr_ptr_r : {IDX_W{1'b0}};
  assign eligible_s   = req_i & ~served_r & ~(wen_i & {N_REQ{fifo_full_s}});
  assign any_elig_s   = |eligible_s;
  assign winner_s     = pick_first(eligible_s, base_s);
  assign grant_s      = any_elig_s & mem.data_gnt;
  assign push_s       = grant_s & wen_i[winner_s];
  assign pop_s        = mem.data_rvalid & ~fifo_empty_s;
  assign grant_mask_s = grant_s ? (N_REQ'(1'b1) << winner_s) : {N_REQ{1'b0}};

  cgra_idx_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUT)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_col_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (winner_s),
    .dout_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Winner's fields onto the port; unused fields are forced to zero.
  always_comb begin
    port_wen_s   = 1'b0;
    port_ind_s   = 1'b0;
    port_add_s   = {DP_WIDTH{1'b0}};
    port_wdata_s = {DP_WIDTH{1'b0}};
    port_inc_s   = {RC_CONST_WIDTH{1'b0}};
    if (any_elig_s) begin
      port_wen_s   = wen_i[winner_s];
      port_ind_s   = ind_i[winner_s];
      port_add_s   = ind_i[winner_s] ? add_i[winner_s] : {DP_WIDTH{1'b0}};
      port_inc_s   = ind_i[winner_s] ? {RC_CONST_WIDTH{1'b0}} : add_inc_i[winner_s];
      port_wdata_s = wen_i[winner_s] ? {DP_WIDTH{1'b0}} : wdata_i[winner_s];
    end else begin
      port_wen_s   = 1'b0;
    end
  end

  assign mem.data_req   = any_elig_s;
  assign mem.data_wen   = port_wen_s;
  assign mem.data_ind   = port_ind_s;
  assign mem.data_add   = port_add_s;
  assign mem.data_wdata = port_wdata_s;
  assign mem.add_inc    = port_inc_s;

  // Read return routed to the FIFO head in the same cycle as the memory valid.
  always_comb begin
    rvalid_s = {N_REQ{1'b0}};
    rdata_s  = {DP_WIDTH{1'b0}};
    if (pop_s) begin
      rvalid_s = N_REQ'(1'b1) << head_s;
      rdata_s  = mem.data_rdata;
    end else begin
      rdata_s  = {DP_WIDTH{1'b0}};
    end
  end

  assign rvalid_o = rvalid_s;
  assign rdata_o  = rdata_s;
  assign rflag_o  = {rdata_s[DP_WIDTH-1], (rdata_s == {DP_WIDTH{1'b0}})};
  assign stall_o  = (|(req_i & ~served_r)) | (|(req_i & wen_i & ~returned_r));
  assign err_o    = err_r;

  // Masks, rotation pointer and sticky error; pc_en clears masks but not the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_col_i) begin
      served_r   <= {N_REQ{1'b0}};
      returned_r <= {N_REQ{1'b0}};
      rr_ptr_r   <= {IDX_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      if (pc_en_i) begin
        served_r   <= {N_REQ{1'b0}};
        returned_r <= {N_REQ{1'b0}};
      end else begin
        served_r   <= served_r | grant_mask_s;
        returned_r <= returned_r | rvalid_s;
      end
      if (grant_s) begin
        rr_ptr_r <= (winner_s == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : winner_s + IDX_W'(1);
      end
      if (mem.data_rvalid & fifo_empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cgra_col_mem_arb.sv
// Directed bench for cgra_col_mem_arb: three configurations share one stimulus.
module tb_cgra_col_mem_arb;
  import cgra_col_mem_arb_pkg::*;

  localparam int NDUT = 3;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A2 = 32'h0000_0120;
  localparam logic [31:0] D0 = 32'h0000_00D0;
  localparam logic [31:0] D1 = 32'h0000_00D1;
  localparam logic [31:0] D2 = 32'h0000_00D2;
  localparam logic [31:0] D3 = 32'h0000_00D3;
  localparam logic [12:0] I1 = 13'h011;
  localparam logic [12:0] I3 = 13'h013;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [12:0] ZI = 13'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, pc_en, gnt, rv;
  logic [3:0]       req, wen, ind;
  logic [3:0][31:0] add, wdata;
  logic [3:0][12:0] add_inc;
  logic [31:0]      rdata;

  logic [3:0]  o_rvalid [NDUT];
  logic [31:0] o_rdata  [NDUT];
  logic [1:0]  o_rflag  [NDUT];
  logic        o_stall  [NDUT];
  logic        o_err    [NDUT];
  logic        o_req    [NDUT];
  logic        o_wen    [NDUT];
  logic        o_ind    [NDUT];
  logic [31:0] o_add    [NDUT];
  logic [31:0] o_wd     [NDUT];
  logic [12:0] o_inc    [NDUT];

  // 0: fixed, MAX_OUT=2   1: round-robin, MAX_OUT=2   2: fixed, MAX_OUT=1
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    cgra_col_mem_arb_if #(.DP_WIDTH(32), .RC_CONST_WIDTH(13)) mif ();
    assign mif.data_gnt    = gnt;
    assign mif.data_rvalid = rv;
    assign mif.data_rdata  = rdata;
    assign o_req[g] = mif.data_req;
    assign o_wen[g] = mif.data_wen;
    assign o_ind[g] = mif.data_ind;
    assign o_add[g] = mif.data_add;
    assign o_wd[g]  = mif.data_wdata;
    assign o_inc[g] = mif.add_inc;

    cgra_col_mem_arb #(
      .N_REQ(4), .DP_WIDTH(32), .RC_CONST_WIDTH(13),
      .MAX_OUT((g == 2) ? 1 : 2),
      .ARB_MODE((g == 1) ? ARB_RR : ARB_FIXED)
    ) dut (
      .clk_i(clk), .rst_col_i(rst), .pc_en_i(pc_en),
      .req_i(req), .wen_i(wen), .ind_i(ind),
      .add_i(add), .wdata_i(wdata), .add_inc_i(add_inc),
      .rvalid_o(o_rvalid[g]), .rdata_o(o_rdata[g]), .rflag_o(o_rflag[g]),
      .stall_o(o_stall[g]), .err_o(o_err[g]), .mem(mif)
    );
  end

  typedef struct {
    int          d;
    logic        chk, rst, pc;
    logic [3:0]  req, wen;
    logic        gnt, rv;
    logic [31:0] rd;
    logic        e_req, e_wen, e_ind;
    logic [31:0] e_add, e_wd;
    logic [12:0] e_inc;
    logic        e_stall;
    logic [3:0]  e_rvalid;
    logic [31:0] e_rdata;
    logic [1:0]  e_rflag;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input int d, input logic chk, rst, pc, input logic [3:0] rq, wn,
                              input logic gt, rvl, input logic [31:0] rd,
                              input logic e_req, e_wen, e_ind, input logic [31:0] e_add, e_wd,
                              input logic [12:0] e_inc, input logic e_stall, input logic [3:0] e_rvalid,
                              input logic [31:0] e_rdata, input logic [1:0] e_rflag, input logic e_err);
    vec_t v;
    v.d = d; v.chk = chk; v.rst = rst; v.pc = pc; v.req = rq; v.wen = wn; v.gnt = gt; v.rv = rvl;
    v.rd = rd; v.e_req = e_req; v.e_wen = e_wen; v.e_ind = e_ind; v.e_add = e_add; v.e_wd = e_wd;
    v.e_inc = e_inc; v.e_stall = e_stall; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
    v.e_rflag = e_rflag; v.e_err = e_err;
    return v;
  endfunction

  function automatic vec_t mk_rst();
    return mk(0, 1'b0, 1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0, 1'b0, Z, Z, ZI, 1'b0, 4'b0, Z, 2'b01, 1'b0);
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst = v.rst; pc_en = v.pc; req = v.req; wen = v.wen;
    gnt = v.gnt; rv = v.rv; rdata = v.rd;
    #2;
    if (v.chk) begin
      cmp("data_req", idx, 32'(o_req[v.d]), 32'(v.e_req));
      cmp("data_wen", idx, 32'(o_wen[v.d]), 32'(v.e_wen));
      cmp("data_ind", idx, 32'(o_ind[v.d]), 32'(v.e_ind));
      cmp("data_add", idx, o_add[v.d], v.e_add);
      cmp("data_wdata", idx, o_wd[v.d], v.e_wd);
      cmp("add_inc", idx, 32'(o_inc[v.d]), 32'(v.e_inc));
      cmp("stall", idx, 32'(o_stall[v.d]), 32'(v.e_stall));
      cmp("rvalid", idx, 32'(o_rvalid[v.d]), 32'(v.e_rvalid));
      cmp("rdata", idx, o_rdata[v.d], v.e_rdata);
      cmp("rflag", idx, 32'(o_rflag[v.d]), 32'(v.e_rflag));
      cmp("err", idx, 32'(o_err[v.d]), 32'(v.e_err));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ind = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      add[k]     = 32'h100 + 32'(k * 16);
      wdata[k]   = 32'hD0 + 32'(k);
      add_inc[k] = 13'h10 + 13'(k);
    end

    // reset state, then fixed-priority writes 1011 (one cycle with gnt low first)
    tbl.push_back(mk_rst());
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b1011,4'b0000,1'b0,1'b0,Z, 1'b1,1'b0,1'b1,A0,D0,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b1011,4'b0000,1'b1,1'b0,Z, 1'b1,1'b0,1'b1,A0,D0,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b1011,4'b0000,1'b1,1'b0,Z, 1'b1,1'b0,1'b0,Z,D1,I1, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b1011,4'b0000,1'b1,1'b0,Z, 1'b1,1'b0,1'b0,Z,D3,I3, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b1011,4'b0000,1'b1,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b0));
    // round-robin: grant RC1 to move rr_ptr to 2, re-arm, then all four write
    tbl.push_back(mk_rst());
    tbl.push_back(mk(1,1'b1,1'b0,1'b0,4'b0010,4'b0000,1'b1,1'b0,Z, 1'b1,1'b0,1'b0,Z,D1,I1, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(1,1'b1,1'b0,1'b1,4'b0000,4'b0000,1'b0,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(1,1'b1,1'b0,1'b0,4'b1111,4'b0000,1'b1,1'b0,Z, 1'b1,1'b0,1'b1,A2,D2,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(1,1'b1,1'b0,1'b0,4'b1111,4'b0000,1'b1,1'b0,Z, 1'b1,1'b0,1'b0,Z,D3,I3, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(1,1'b1,1'b0,1'b0,4'b1111,4'b0000,1'b1,1'b0,Z, 1'b1,1'b0,1'b1,A0,D0,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(1,1'b1,1'b0,1'b0,4'b1111,4'b0000,1'b1,1'b0,Z, 1'b1,1'b0,1'b0,Z,D1,I1, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(1,1'b1,1'b0,1'b0,4'b1111,4'b0000,1'b1,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b0));
    // two reads (RC1, RC3) with MAX_OUT=2; returns 0x80000000 then 0
    tbl.push_back(mk_rst());
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b1010,4'b1010,1'b1,1'b0,Z, 1'b1,1'b1,1'b0,Z,Z,I1, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b1010,4'b1010,1'b1,1'b0,Z, 1'b1,1'b1,1'b0,Z,Z,I3, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b1010,4'b1010,1'b1,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b1010,4'b1010,1'b1,1'b1,32'h8000_0000, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b0010,32'h8000_0000,2'b10,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b1010,4'b1010,1'b1,1'b1,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b1000,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b1010,4'b1010,1'b1,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b0));
    // MAX_OUT=1: RC2's read is held off until RC0's return
    tbl.push_back(mk_rst());
    tbl.push_back(mk(2,1'b1,1'b0,1'b0,4'b0101,4'b0101,1'b1,1'b0,Z, 1'b1,1'b1,1'b1,A0,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(2,1'b1,1'b0,1'b0,4'b0101,4'b0101,1'b1,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(2,1'b1,1'b0,1'b0,4'b0101,4'b0101,1'b1,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(2,1'b1,1'b0,1'b0,4'b0101,4'b0101,1'b1,1'b1,32'h1234, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b0001,32'h1234,2'b00,1'b0));
    tbl.push_back(mk(2,1'b1,1'b0,1'b0,4'b0101,4'b0101,1'b1,1'b0,Z, 1'b1,1'b1,1'b1,A2,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(2,1'b1,1'b0,1'b0,4'b0101,4'b0101,1'b1,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(2,1'b1,1'b0,1'b0,4'b0101,4'b0101,1'b1,1'b1,32'h5, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b0100,32'h5,2'b00,1'b0));
    tbl.push_back(mk(2,1'b1,1'b0,1'b0,4'b0101,4'b0101,1'b1,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b0));
    // pc_en while RC0's read is in flight: re-grant, returns still reach RC0
    tbl.push_back(mk_rst());
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b0001,4'b0001,1'b1,1'b0,Z, 1'b1,1'b1,1'b1,A0,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b1,4'b0001,4'b0001,1'b1,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b0001,4'b0001,1'b1,1'b0,Z, 1'b1,1'b1,1'b1,A0,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b0001,4'b0001,1'b1,1'b1,32'h7, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b0001,32'h7,2'b00,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b0001,4'b0001,1'b1,1'b1,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0001,Z,2'b01,1'b0));
    tbl.push_back(mk(0,1'b1,1'b0,1'b0,4'b0001,4'b0001,1'b1,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Sticky error on a stray return; reset clears error, masks and FIFO together.
    apply(mk_rst(), 100);
    apply(mk(0,1'b1,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b1,32'h9, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b0), 101);
    apply(mk(0,1'b1,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b1), 102);
    apply(mk(0,1'b1,1'b0,1'b1,4'b0000,4'b0000,1'b0,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b1), 103);
    apply(mk(0,1'b1,1'b0,1'b0,4'b0001,4'b0001,1'b1,1'b0,Z, 1'b1,1'b1,1'b1,A0,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b1), 104);
    apply(mk(0,1'b1,1'b1,1'b1,4'b0001,4'b0001,1'b0,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b1), 105);
    apply(mk(0,1'b1,1'b0,1'b0,4'b0001,4'b0001,1'b0,1'b0,Z, 1'b1,1'b1,1'b1,A0,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b0), 106);
    apply(mk(0,1'b1,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b1,32'h9, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b0), 107);
    apply(mk(0,1'b1,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b1), 108);

    // Push and pop in the same cycle keep the count: RC1's read follows RC0's.
    apply(mk_rst(), 200);
    apply(mk(0,1'b1,1'b0,1'b0,4'b0001,4'b0001,1'b1,1'b0,Z, 1'b1,1'b1,1'b1,A0,Z,ZI, 1'b1,4'b0,Z,2'b01,1'b0), 201);
    apply(mk(0,1'b1,1'b0,1'b0,4'b0011,4'b0011,1'b1,1'b1,32'h55, 1'b1,1'b1,1'b0,Z,Z,I1, 1'b1,4'b0001,32'h55,2'b00,1'b0), 202);
    apply(mk(0,1'b1,1'b0,1'b0,4'b0011,4'b0011,1'b0,1'b1,32'h66, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b1,4'b0010,32'h66,2'b00,1'b0), 203);
    apply(mk(0,1'b1,1'b0,1'b0,4'b0011,4'b0011,1'b0,1'b0,Z, 1'b0,1'b0,1'b0,Z,Z,ZI, 1'b0,4'b0,Z,2'b01,1'b0), 204);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
